jb_ul_oran_section_sched: RTL and testbench

Consumes 24-bit UL O-RAN section requests from the upstream request FIFO and splits each into one or more C-plane section descriptors of at most MAX_SECT_PRB PRBs. Descriptors go to the downstream packetiser over a valid/ready handshake. Malformed requests are range-checked and dropped with an error pulse.

---
 rtl/jb_ul_oran_pkg.sv | 49 ++++
 rtl/jb_ul_oran_section_sched_if.sv | 31 +++
 rtl/jb_ul_oran_section_sched.sv | 140 ++++++++++++++
 tb/tb_jb_ul_oran_section_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jb_ul_oran_pkg.sv
// Shared types for the UL O-RAN section scheduler: request word layout,
// section descriptor and FSM state encoding.
package jb_ul_oran_pkg;

   localparam int REQ_W       = 24;
   localparam int PORT_LSB    = 21;
   localparam int PORT_W      = 3;
   localparam int SYM_LSB     = 17;
   localparam int SYM_W       = 4;
   localparam int START_LSB   = 8;
   localparam int START_W     = 9;
   localparam int NUM_LSB     = 0;
   localparam int NUM_W       = 8;

   localparam int NUM_SYMBOLS     = 14;
   localparam int NUM_PRB_MAX_DEF = 273;

   typedef struct packed {
      logic [PORT_W-1:0]  port;
      logic [SYM_W-1:0]   symbol;
      logic [START_W-1:0] start_prb;
      logic [NUM_W-1:0]   num_prb;
   } ul_req_t;

   typedef struct packed {
      logic [PORT_W-1:0]  port;
      logic [SYM_W-1:0]   symbol;
      logic [START_W-1:0] start_prb;
      logic [NUM_W-1:0]   num_prb;
      logic               last;
   } sect_desc_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_ISSUE = 2'd2
   } sched_state_e;

   // Size of the next section: whatever remains, capped at the per-section limit.
   function automatic logic [NUM_W-1:0] chunk_len(input logic [NUM_W-1:0] rem,
                                                  input logic [NUM_W-1:0] max_prb);
      if (rem > max_prb) begin
         chunk_len = max_prb;
      end else begin
         chunk_len = rem;
      end
   endfunction

endpackage

// File: rtl/jb_ul_oran_section_sched_if.sv
// Upstream FIFO read port and downstream section descriptor channel.
interface jb_ul_oran_section_sched_if
   import jb_ul_oran_pkg::*;
#(
   parameter int SECT_ID_W = 12
);
   logic                 fifo_empty;
   logic [REQ_W-1:0]     fifo_read_data;
   logic                 fifo_read;

   logic                 sect_valid;
   logic                 sect_ready;
   logic [PORT_W-1:0]    sect_port;
   logic [SYM_W-1:0]     sect_symbol;
   logic [START_W-1:0]   sect_start_prb;
   logic [NUM_W-1:0]     sect_num_prb;
   logic [SECT_ID_W-1:0] sect_id;
   logic                 sect_last;

   modport master (
      input  fifo_empty, fifo_read_data, sect_ready,
      output fifo_read, sect_valid, sect_port, sect_symbol,
             sect_start_prb, sect_num_prb, sect_id, sect_last
   );

   modport slave (
      output fifo_empty, fifo_read_data, sect_ready,
      input  fifo_read, sect_valid, sect_port, sect_symbol,
             sect_start_prb, sect_num_prb, sect_id, sect_last
   );
endinterface

// File: rtl/jb_ul_oran_section_sched.sv
// Pops UL section requests, range-checks them and splits each into C-plane
// section descriptors of at most MAX_SECT_PRB PRBs.
module jb_ul_oran_section_sched
   import jb_ul_oran_pkg::*;
#(
   parameter int MAX_SECT_PRB = 64,
   parameter int NUM_PRB_MAX  = NUM_PRB_MAX_DEF,
   parameter int SECT_ID_W    = 12
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   jb_ul_oran_section_sched_if.master  sif,
   output logic                        req_err,
   output logic                        busy,
   output logic [15:0]                 req_count
);

   localparam logic [NUM_W-1:0]     MAX_C    = NUM_W'(MAX_SECT_PRB);
   localparam logic [9:0]           PRB_LIM  = 10'(NUM_PRB_MAX);
   localparam logic [SYM_W-1:0]     SYM_LAST = SYM_W'(NUM_SYMBOLS - 1);
   localparam logic [SECT_ID_W-1:0] ID_ONE   = {{(SECT_ID_W-1){1'b0}}, 1'b1};

   sched_state_e         state_q, state_d;
   ul_req_t              req_q, req_d;
   logic [NUM_W-1:0]     rem_q, rem_d;
   sect_desc_t           desc_q, desc_d;
   logic                 sect_valid_q, sect_valid_d;
   logic [SECT_ID_W-1:0] sect_id_q, sect_id_d;
   logic [15:0]          req_count_q, req_count_d;
   logic                 req_err_q, req_err_d;

   logic                 pop_s;
   logic [9:0]           end_prb_s;
   logic [NUM_W-1:0]     rem_nxt_s;

   // The pop must be combinational so the head word is captured in the same cycle.
   assign pop_s = enable & ~sif.fifo_empty & (state_q == ST_IDLE);

   // Next-state, descriptor and counter logic.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      rem_d        = rem_q;
      desc_d       = desc_q;
      sect_valid_d = sect_valid_q;
      sect_id_d    = sect_id_q;
      req_count_d  = req_count_q;
      req_err_d    = 1'b0;
      end_prb_s    = {1'b0, req_q.start_prb} + {2'b00, req_q.num_prb};
      rem_nxt_s    = rem_q - desc_q.num_prb;

      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               req_d   = ul_req_t'(sif.fifo_read_data);
               state_d = ST_CHECK;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_CHECK: begin
            if ((req_q.num_prb == 8'd0) || (end_prb_s > PRB_LIM) ||
                (req_q.symbol > SYM_LAST)) begin
               req_err_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               rem_d            = req_q.num_prb;
               desc_d.port      = req_q.port;
               desc_d.symbol    = req_q.symbol;
               desc_d.start_prb = req_q.start_prb;
               desc_d.num_prb   = chunk_len(req_q.num_prb, MAX_C);
               desc_d.last      = (req_q.num_prb <= MAX_C);
               sect_valid_d     = 1'b1;
               state_d          = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (sif.sect_ready) begin
               sect_id_d = sect_id_q + ID_ONE;
               if (desc_q.last) begin
                  sect_valid_d = 1'b0;
                  req_count_d  = req_count_q + 16'd1;
                  state_d      = ST_IDLE;
               end else begin
                  rem_d            = rem_nxt_s;
                  desc_d.start_prb = desc_q.start_prb + {1'b0, desc_q.num_prb};
                  desc_d.num_prb   = chunk_len(rem_nxt_s, MAX_C);
                  desc_d.last      = (rem_nxt_s <= MAX_C);
               end
            end else begin
               sect_valid_d = 1'b1;
            end
         end

         default: begin
            sect_valid_d = 1'b0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any partially issued request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         rem_q        <= '0;
         desc_q       <= '0;
         sect_valid_q <= 1'b0;
         sect_id_q    <= '0;
         req_count_q  <= 16'd0;
         req_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         rem_q        <= rem_d;
         desc_q       <= desc_d;
         sect_valid_q <= sect_valid_d;
         sect_id_q    <= sect_id_d;
         req_count_q  <= req_count_d;
         req_err_q    <= req_err_d;
      end
   end

   assign sif.fifo_read      = pop_s;
   assign sif.sect_valid     = sect_valid_q;
   assign sif.sect_port      = desc_q.port;
   assign sif.sect_symbol    = desc_q.symbol;
   assign sif.sect_start_prb = desc_q.start_prb;
   assign sif.sect_num_prb   = desc_q.num_prb;
   assign sif.sect_last      = desc_q.last;
   assign sif.sect_id        = sect_id_q;
   assign req_err            = req_err_q;
   assign busy               = (state_q != ST_IDLE);
   assign req_count          = req_count_q;

endmodule

// File: tb/tb_jb_ul_oran_section_sched.sv
// Directed bench for jb_ul_oran_section_sched with a queue-backed FIFO model.
module tb_jb_ul_oran_section_sched;
   import jb_ul_oran_pkg::*;

   typedef struct packed {
      logic [2:0]  port;
      logic [3:0]  sym;
      logic [8:0]  start;
      logic [7:0]  num;
      logic        last;
      logic [11:0] id;
   } cap_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        req_err;
   logic        busy;
   logic [15:0] req_count;

   int n_checks = 0;
   int n_errors = 0;
   int pop_cnt = 0;
   int err_cnt = 0;
   int gate_viol = 0;
   int underflow = 0;
   int cyc = 0;
   int exp_id = 0;
   int exp_req = 0;

   logic [23:0] fifo_q[$];
   cap_t        cap_q[$];
   int          stamp_q[$];

   jb_ul_oran_section_sched_if #(.SECT_ID_W(12)) sif();

   jb_ul_oran_section_sched #(
      .MAX_SECT_PRB(64),
      .NUM_PRB_MAX (273),
      .SECT_ID_W   (12)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .sif      (sif),
      .req_err  (req_err),
      .busy     (busy),
      .req_count(req_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: pops one word shortly after each edge that saw fifo_read.
   always @(posedge clk) begin
      if (sif.fifo_read === 1'b1) begin
         #1;
         if (fifo_q.size() == 0) begin
            underflow <= underflow + 1;
         end else begin
            fifo_q.delete(0);
            pop_cnt <= pop_cnt + 1;
            stamp_q.push_back(cyc);
         end
         fifo_refresh();
      end
   end

   always @(posedge clk) begin
      if (rst_n && sif.sect_valid && sif.sect_ready)
         cap_q.push_back({sif.sect_port, sif.sect_symbol, sif.sect_start_prb,
                          sif.sect_num_prb, sif.sect_last, sif.sect_id});
      if (rst_n && req_err) err_cnt <= err_cnt + 1;
      if (sif.fifo_read && busy) gate_viol <= gate_viol + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fifo_refresh();
      sif.fifo_empty     = (fifo_q.size() == 0);
      sif.fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : 24'h0;
   endtask

   task automatic push_req(input logic [2:0] p, input logic [3:0] s,
                           input logic [8:0] st, input logic [7:0] n);
      fifo_q.push_back({p, s, st, n});
      fifo_refresh();
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((fifo_q.size() != 0 || busy) && n < budget);
      check_eq({tag, "_timeout"}, 48'(n >= budget), 48'd0);
      @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!sif.sect_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 48'(sif.sect_valid), 48'd1);
   endtask

   task automatic exp_desc(input string tag, input logic [2:0] p, input logic [3:0] s,
                           input logic [8:0] st, input logic [7:0] n, input logic l);
      cap_t c;
      cap_t e;
      c = (cap_q.size() != 0) ? cap_q.pop_front() : '1;
      e = {p, s, st, n, l, 12'(exp_id)};
      check_eq(tag, 48'(c), 48'(e));
      exp_id = (exp_id + 1) % 4096;
   endtask

   function automatic cap_t live_desc();
      return {sif.sect_port, sif.sect_symbol, sif.sect_start_prb,
              sif.sect_num_prb, sif.sect_last, sif.sect_id};
   endfunction

   logic [8:0] t2_start[3] = '{9'd10, 9'd74, 9'd138};
   logic [7:0] t2_num[3]   = '{8'd64, 8'd64, 8'd22};
   logic       t2_last[3]  = '{1'b0, 1'b0, 1'b1};

   initial begin
      int p0, e0, bad, need;
      sif.fifo_empty     = 1'b1;
      sif.fifo_read_data = 24'h0;
      sif.sect_ready     = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_valid", 48'(sif.sect_valid), 48'd0);
      check_eq("rst_busy", 48'(busy), 48'd0);
      check_eq("rst_id", 48'(sif.sect_id), 48'd0);
      check_eq("rst_count", 48'(req_count), 48'd0);
      check_eq("rst_err", 48'(req_err), 48'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single-section request and latency
      enable = 1'b1;
      sif.sect_ready = 1'b1;
      push_req(3'd2, 4'd5, 9'd10, 8'd20);
      #1;
      check_eq("t1_pop", 48'(sif.fifo_read), 48'd1);
      @(negedge clk);
      check_eq("t1_check_busy", 48'(busy), 48'd1);
      check_eq("t1_check_novalid", 48'(sif.sect_valid), 48'd0);
      @(negedge clk);
      check_eq("t1_live", 48'(live_desc()), 48'({3'd2, 4'd5, 9'd10, 8'd20, 1'b1, 12'd0}));
      check_eq("t1_nopop", 48'(sif.fifo_read), 48'd0);
      @(negedge clk);
      check_eq("t1_idle", 48'(busy), 48'd0);
      check_eq("t1_count", 48'(req_count), 48'd1);
      check_eq("t1_id_after", 48'(sif.sect_id), 48'd1);
      exp_desc("t1_desc", 3'd2, 4'd5, 9'd10, 8'd20, 1'b1);
      exp_req = 1;

      // 2: three-way split
      cap_q.delete();
      push_req(3'd0, 4'd1, 9'd10, 8'd150);
      wait_done("t2", 50);
      check_eq("t2_n", 48'(cap_q.size()), 48'd3);
      for (int k = 0; k < 3; k++) exp_desc("t2_desc", 3'd0, 4'd1, t2_start[k], t2_num[k], t2_last[k]);
      exp_req++;
      check_eq("t2_count", 48'(req_count), 48'(exp_req));

      // 3: same split with a 5-cycle stall on every section
      cap_q.delete();
      sif.sect_ready = 1'b0;
      p0 = pop_cnt;
      push_req(3'd0, 4'd1, 9'd10, 8'd150);
      for (int k = 0; k < 3; k++) begin
         wait_valid("t3_valid");
         repeat (5) begin
            @(negedge clk);
            check_eq("t3_stable", 48'(live_desc()),
                     48'({3'd0, 4'd1, t2_start[k], t2_num[k], t2_last[k], 12'(exp_id + k)}));
         end
         check_eq("t3_pops", 48'(pop_cnt - p0), 48'd1);
         sif.sect_ready = 1'b1;
         @(negedge clk);
         sif.sect_ready = 1'b0;
      end
      sif.sect_ready = 1'b1;
      wait_done("t3", 50);
      check_eq("t3_n", 48'(cap_q.size()), 48'd3);
      for (int k = 0; k < 3; k++) exp_desc("t3_desc", 3'd0, 4'd1, t2_start[k], t2_num[k], t2_last[k]);
      exp_req++;

      // 4: malformed requests and the end==NUM_PRB_MAX boundary
      cap_q.delete();
      e0 = err_cnt;
      push_req(3'd1, 4'd2, 9'd260, 8'd20);
      wait_done("t4a", 20);
      check_eq("t4_err_end", 48'(err_cnt - e0), 48'd1);
      push_req(3'd1, 4'd2, 9'd5, 8'd0);
      wait_done("t4b", 20);
      check_eq("t4_err_num0", 48'(err_cnt - e0), 48'd2);
      push_req(3'd1, 4'd14, 9'd5, 8'd20);
      wait_done("t4c", 20);
      check_eq("t4_err_sym", 48'(err_cnt - e0), 48'd3);
      check_eq("t4_no_desc", 48'(cap_q.size()), 48'd0);
      check_eq("t4_id_kept", 48'(sif.sect_id), 48'(exp_id));
      check_eq("t4_count_kept", 48'(req_count), 48'(exp_req));
      push_req(3'd3, 4'd13, 9'd253, 8'd20);
      wait_done("t4d", 20);
      check_eq("t4_edge_noerr", 48'(err_cnt - e0), 48'd3);
      exp_desc("t4_edge_desc", 3'd3, 4'd13, 9'd253, 8'd20, 1'b1);
      exp_req++;

      // 5: gating by fifo_empty and enable, then 4 back-to-back requests
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (sif.fifo_read || busy) bad++;
      end
      check_eq("t5_empty_idle", 48'(bad), 48'd0);
      enable = 1'b0;
      p0 = pop_cnt;
      for (int k = 0; k < 4; k++) push_req(3'(k), 4'(k), 9'(8 * k), 8'd8);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (sif.fifo_read || busy) bad++;
      end
      check_eq("t5_disabled_idle", 48'(bad), 48'd0);
      check_eq("t5_disabled_pops", 48'(pop_cnt - p0), 48'd0);
      cap_q.delete();
      stamp_q.delete();
      enable = 1'b1;
      wait_done("t5", 60);
      check_eq("t5_pops", 48'(pop_cnt - p0), 48'd4);
      check_eq("t5_gate", 48'(gate_viol), 48'd0);
      for (int k = 1; k < 4; k++)
         check_eq("t5_period", 48'((stamp_q.size() > k) ? stamp_q[k] - stamp_q[k-1] : 0), 48'd3);
      for (int k = 0; k < 4; k++) exp_desc("t5_desc", 3'(k), 4'(k), 9'(8 * k), 8'd8, 1'b1);
      exp_req += 4;
      check_eq("t5_count", 48'(req_count), 48'(exp_req));

      // Enable dropped mid-request: current request finishes, no new pop
      cap_q.delete();
      p0 = pop_cnt;
      push_req(3'd4, 4'd2, 9'd0, 8'd100);
      push_req(3'd5, 4'd3, 9'd100, 8'd100);
      @(negedge clk);
      enable = 1'b0;
      repeat (12) @(negedge clk);
      check_eq("t5e_pops", 48'(pop_cnt - p0), 48'd1);
      check_eq("t5e_n", 48'(cap_q.size()), 48'd2);
      check_eq("t5e_idle", 48'(busy), 48'd0);
      enable = 1'b1;
      wait_done("t5e", 40);
      check_eq("t5e_pops2", 48'(pop_cnt - p0), 48'd2);
      exp_desc("t5e_d0", 3'd4, 4'd2, 9'd0, 8'd64, 1'b0);
      exp_desc("t5e_d1", 3'd4, 4'd2, 9'd64, 8'd36, 1'b1);
      exp_desc("t5e_d2", 3'd5, 4'd3, 9'd100, 8'd64, 1'b0);
      exp_desc("t5e_d3", 3'd5, 4'd3, 9'd164, 8'd36, 1'b1);
      exp_req += 2;

      // 6: section ID wrap
      need = 4095 - exp_id;
      while (need >= 4) begin
         push_req(3'd0, 4'd0, 9'd0, 8'd255);
         need -= 4;
         exp_id += 4;
         exp_req++;
      end
      while (need > 0) begin
         push_req(3'd0, 4'd0, 9'd0, 8'd1);
         need--;
         exp_id++;
         exp_req++;
      end
      wait_done("t6_fill", 20000);
      check_eq("t6_id_4095", 48'(sif.sect_id), 48'd4095);
      check_eq("t6_count", 48'(req_count), 48'(exp_req % 65536));
      cap_q.delete();
      push_req(3'd6, 4'd7, 9'd1, 8'd2);
      push_req(3'd7, 4'd8, 9'd3, 8'd4);
      wait_done("t6_wrap", 20);
      exp_desc("t6_last_id", 3'd6, 4'd7, 9'd1, 8'd2, 1'b1);
      exp_desc("t6_wrapped_id", 3'd7, 4'd8, 9'd3, 8'd4, 1'b1);
      check_eq("t6_id_now", 48'(sif.sect_id), 48'd1);

      // Asynchronous reset in the middle of ISSUE
      sif.sect_ready = 1'b0;
      push_req(3'd1, 4'd1, 9'd0, 8'd200);
      wait_valid("t6r_valid");
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6r_valid", 48'(sif.sect_valid), 48'd0);
      check_eq("t6r_busy", 48'(busy), 48'd0);
      check_eq("t6r_id", 48'(sif.sect_id), 48'd0);
      check_eq("t6r_count", 48'(req_count), 48'd0);
      check_eq("t6r_num", 48'(sif.sect_num_prb), 48'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sif.sect_ready = 1'b1;
      cap_q.delete();
      exp_id = 0;
      push_req(3'd5, 4'd3, 9'd7, 8'd9);
      wait_done("t6r", 20);
      exp_desc("t6r_desc", 3'd5, 4'd3, 9'd7, 8'd9, 1'b1);
      check_eq("t6r_count_after", 48'(req_count), 48'd1);
      check_eq("underflow", 48'(underflow), 48'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
